// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for serial_sub_ctrl.
// The out_zero/out_lt flag signals exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_sub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             out_zero;
    logic             out_lt;

    modport master (
        output in_valid, in_a, in_b, in_bin, out_ready,
        input  in_ready, out_valid, out_diff, out_bout, out_zero, out_lt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bin, out_ready,
        output in_ready, out_valid, out_diff, out_bout, out_zero, out_lt
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_bin, out_ready,
        input  in_ready, out_valid, out_diff, out_bout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bin, out_ready,
        output in_ready, out_valid, out_diff, out_bout
    );
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fullsubtractor cell time-shared LSB-first over WIDTH bits.
// Define SERIAL_SUB_FLAGS_EN to add the out_zero / out_lt result flags.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             cell_diff_c;
    logic             cell_bout_c;
    logic             last_bit_c;
    logic [WIDTH-1:0] r_sh_d;

    fullsubtractor u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (brw_q),
        .diff_o (cell_diff_c),
        .bout_o (cell_bout_c)
    );

    // New difference bit enters at the MSB so the result lands LSB-aligned after WIDTH shifts.
    assign r_sh_d     = (r_sh_q >> 1) | (WIDTH'(cell_diff_c) << (WIDTH - 1));
    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_FLAGS_EN
    logic nz_q;
    logic out_zero_q;
    logic out_lt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_sh_q      <= '0;
            brw_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            nz_q        <= 1'b0;
            out_zero_q  <= 1'b0;
            out_lt_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh_q     <= bus.in_a;
                        b_sh_q     <= bus.in_b;
                        brw_q      <= bus.in_bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                        nz_q       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    brw_q  <= cell_bout_c;
                    r_sh_q <= r_sh_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_FLAGS_EN
                    nz_q   <= nz_q | cell_diff_c;
`endif
                    if (last_bit_c) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        out_zero_q  <= ~(nz_q | cell_diff_c);
                        out_lt_q    <= cell_bout_c;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
`ifdef SERIAL_SUB_FLAGS_EN
                        out_zero_q  <= 1'b0;
                        out_lt_q    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_diff  = r_sh_q;
    assign bus.out_bout  = brw_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign bus.out_zero  = out_zero_q;
    assign bus.out_lt    = out_lt_q;
`endif

endmodule

// Single-bit full subtractor: diff = a - b - bin, bout = borrow out.
module fullsubtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);
    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule
